// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-fed byte serializer.
package fifo_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned FIFO_SIZE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_e;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick        = (cnt_q == LAST);
    // Lets the parent register a pulse that lines up with next cycle's tick.
    assign tick_next_c = (cnt_d == LAST);

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pulls bytes from a sync FIFO and sends them as start / 8 data LSB-first / [parity] / stop frames.
module fifo_byte_serializer
    import fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 read_enable,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic                   serial_out_q, serial_out_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   baud_clear;
    logic                   tick;
    logic                   tick_next;

    assign baud_clear = (state_q == ST_LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (baud_clear),
        .tick        (tick),
        .tick_next_c (tick_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_cnt_q == LAST_BIT)) begin
                    state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) state_d = ST_STOP;
            ST_STOP:   if (tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath and output logic; line outputs are derived from the next state so
    // the registered outputs line up with state_q.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        case (state_q)
            ST_LOAD: begin
                shift_d   = fifo_data;
                bit_cnt_d = '0;
                parity_d  = even_parity(fifo_data);
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: begin
            end
        endcase

        serial_out_d = 1'b1;
        case (state_d)
            ST_START:  serial_out_d = 1'b0;
            ST_DATA:   serial_out_d = shift_d[0];
            ST_PARITY: serial_out_d = parity_d;
            default:   serial_out_d = 1'b1;
        endcase

        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_q == ST_STOP) && tick_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            parity_q     <= 1'b0;
            serial_out_q <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_q     <= parity_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Single-cycle read request; gated by reset so a held reset never pops the FIFO.
    assign read_enable = (state_q == ST_IDLE) && !fifo_empty && !rst;
    assign serial_out  = serial_out_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench: three serializer configurations, each fed by a small FIFO model.
module tb_fifo_byte_serializer;
    import fifo_pkg::*;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty  [NDUT];
    logic [7:0] fifo_data   [NDUT];
    logic       read_enable [NDUT];
    logic       serial_out  [NDUT];
    logic       busy        [NDUT];
    logic       frame_done  [NDUT];
    int         reads_cnt   [NDUT];
    int         bad_reads   [NDUT];
    logic [7:0] mem [NDUT][FIFO_SIZE];
    int         wr_ptr [NDUT] = '{0, 0, 0};
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // DUT 0: 4 clk/bit, no parity. DUT 1: 4 clk/bit, parity. DUT 2: 2 clk/bit, no parity.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned CPB = (g == 2) ? 2 : 4;
        localparam bit          PEN = (g == 1);
        int         rd_ptr = 0;
        int         reads  = 0;
        int         bad    = 0;
        logic [7:0] dq     = 8'h00;

        always @(posedge clk) begin
            if (read_enable[g] === 1'b1) begin
                if (fifo_empty[g] || rst) bad <= bad + 1;
                dq     <= mem[g][rd_ptr % FIFO_SIZE];
                rd_ptr <= rd_ptr + 1;
                reads  <= reads + 1;
            end
        end

        assign fifo_empty[g] = (wr_ptr[g] == rd_ptr);
        assign fifo_data[g]  = dq;
        assign reads_cnt[g]  = reads;
        assign bad_reads[g]  = bad;

        fifo_byte_serializer #(
            .CLKS_PER_BIT (CPB),
            .PARITY_EN    (PEN)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .fifo_empty  (fifo_empty[g]),
            .fifo_data   (fifo_data[g]),
            .read_enable (read_enable[g]),
            .serial_out  (serial_out[g]),
            .busy        (busy[g]),
            .frame_done  (frame_done[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int g, input logic [7:0] b);
        mem[g][wr_ptr[g] % FIFO_SIZE] = b;
        wr_ptr[g]++;
    endtask

    // Waits for a read, then records one line sample per bit and frame_done position.
    task automatic capture(input int g, input int cpb, input int nbits,
                           output logic [10:0] bits, output int fd_off, output int fd_cnt,
                           output bit stable, output bit busy_ok, output int waited,
                           output bit timeout);
        bits = '0; fd_off = -1; fd_cnt = 0; stable = 1'b1; busy_ok = 1'b1;
        waited = 0; timeout = 1'b0;
        #1;
        while (read_enable[g] !== 1'b1 && waited < 400) begin
            step();
            waited++;
        end
        if (read_enable[g] !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (serial_out[g] !== 1'b1) stable = 1'b0;
            if ((i > 0) && (busy[g] !== 1'b1)) busy_ok = 1'b0;
            step();
        end
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (c == 0) bits[b] = serial_out[g];
                else if (serial_out[g] !== bits[b]) stable = 1'b0;
                if (busy[g] !== 1'b1) busy_ok = 1'b0;
                if (frame_done[g] === 1'b1) begin
                    fd_cnt++;
                    fd_off = b * cpb + c;
                end
                step();
            end
        end
    endtask

    task automatic test_reset();
        int re_seen = 0;
        rst = 1'b1;
        push(1, 8'h07);
        for (int i = 0; i < 4; i++) begin
            step();
            if (read_enable[1] !== 1'b0) re_seen++;
        end
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if ({serial_out[g], busy[g], frame_done[g], read_enable[g]} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %b expected 1000", g,
                         {serial_out[g], busy[g], frame_done[g], read_enable[g]});
            end
        end
        checks++;
        if (re_seen !== 0) begin
            errors++;
            $display("FAIL reset_holds_read: got %0d read cycles expected 0", re_seen);
        end
        rst = 1'b0;
    endtask

    task automatic test_parity();
        logic [10:0] bits; int fd_off, fd_cnt, waited; bit stable, busy_ok, timeout;
        capture(1, 4, 11, bits, fd_off, fd_cnt, stable, busy_ok, waited, timeout);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL parity_timeout: got 1 expected 0"); end
        checks++;
        if (bits !== 11'h60E) begin
            errors++; $display("FAIL parity_frame: got %h expected 60e", bits);
        end
        checks++;
        if ((fd_off !== 43) || (fd_cnt !== 1)) begin
            errors++; $display("FAIL parity_len: got off=%0d n=%0d expected off=43 n=1", fd_off, fd_cnt);
        end
        checks++;
        if ((stable !== 1'b1) || (busy_ok !== 1'b1)) begin
            errors++; $display("FAIL parity_timing: got stable=%0d busy=%0d expected 1 1", stable, busy_ok);
        end
    endtask

    task automatic test_idle_empty();
        int re_seen = 0, line_low = 0, busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (read_enable[0] !== 1'b0) re_seen++;
            if (serial_out[0] !== 1'b1) line_low++;
            if (busy[0] !== 1'b0) busy_seen++;
        end
        checks++;
        if ({re_seen, line_low, busy_seen} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL idle_empty: got re=%0d low=%0d busy=%0d expected 0 0 0",
                     re_seen, line_low, busy_seen);
        end
    endtask

    task automatic test_frame_a5();
        logic [10:0] bits; int fd_off, fd_cnt, waited; bit stable, busy_ok, timeout;
        int r0 = reads_cnt[0];
        int re_seen = 0;
        push(0, 8'hA5);
        capture(0, 4, 10, bits, fd_off, fd_cnt, stable, busy_ok, waited, timeout);
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL a5_timeout: got 1 expected 0"); end
        checks++;
        if (bits[9:0] !== 10'h34A) begin
            errors++; $display("FAIL a5_frame: got %h expected 34a", bits[9:0]);
        end
        checks++;
        if ((fd_off !== 39) || (fd_cnt !== 1)) begin
            errors++; $display("FAIL a5_len: got off=%0d n=%0d expected off=39 n=1", fd_off, fd_cnt);
        end
        checks++;
        if ((stable !== 1'b1) || (busy_ok !== 1'b1)) begin
            errors++; $display("FAIL a5_timing: got stable=%0d busy=%0d expected 1 1", stable, busy_ok);
        end
        checks++;
        if ({busy[0], serial_out[0]} !== 2'b01) begin
            errors++; $display("FAIL a5_after: got busy,line=%b expected 01", {busy[0], serial_out[0]});
        end
        for (int i = 0; i < 10; i++) begin
            if (read_enable[0] !== 1'b0) re_seen++;
            step();
        end
        checks++;
        if ((reads_cnt[0] - r0 !== 1) || (re_seen !== 0)) begin
            errors++;
            $display("FAIL a5_reads: got %0d reads, %0d idle reads expected 1, 0", reads_cnt[0] - r0, re_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits; int fd_off, fd_cnt, waited; bit stable, busy_ok, timeout;
        logic [9:0] exp_b [3];
        int r0 = reads_cnt[0];
        int re_seen = 0;
        exp_b = '{10'h202, 10'h204, 10'h206};
        push(0, 8'h01); push(0, 8'h02); push(0, 8'h03);
        for (int i = 0; i < 3; i++) begin
            capture(0, 4, 10, bits, fd_off, fd_cnt, stable, busy_ok, waited, timeout);
            checks++;
            if ((timeout !== 1'b0) || (bits[9:0] !== exp_b[i]) || (fd_off !== 39)) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h off=%0d to=%0d expected %h off=39 to=0",
                         i, bits[9:0], fd_off, timeout, exp_b[i]);
            end
            if (i > 0) begin
                checks++;
                if ((waited !== 0) || (stable !== 1'b1)) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got wait=%0d stable=%0d expected 0 1", i, waited, stable);
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            if (read_enable[0] !== 1'b0) re_seen++;
            step();
        end
        checks++;
        if ((reads_cnt[0] - r0 !== 3) || (re_seen !== 0) || (busy[0] !== 1'b0)) begin
            errors++;
            $display("FAIL b2b_reads: got %0d reads idle_re=%0d busy=%0d expected 3 0 0",
                     reads_cnt[0] - r0, re_seen, busy[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] bits; int fd_off, fd_cnt, waited; bit stable, busy_ok, timeout;
        int r0 = reads_cnt[0];
        int w = 0;
        int re_seen = 0;
        push(0, 8'hFF); push(0, 8'h3C);
        #1;
        while (read_enable[0] !== 1'b1 && w < 400) begin step(); w++; end
        checks++;
        if (read_enable[0] !== 1'b1) begin
            errors++; $display("FAIL midrst_timeout: got no read expected read");
        end
        // 20 cycles after the read sits in the middle of data bit 3.
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if ({serial_out[0], busy[0], frame_done[0]} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_abort: got %b expected 100", {serial_out[0], busy[0], frame_done[0]});
        end
        for (int i = 0; i < 4; i++) begin
            if (read_enable[0] !== 1'b0) re_seen++;
            step();
        end
        checks++;
        if (re_seen !== 0) begin
            errors++; $display("FAIL midrst_no_read: got %0d expected 0", re_seen);
        end
        rst = 1'b0;
        capture(0, 4, 10, bits, fd_off, fd_cnt, stable, busy_ok, waited, timeout);
        checks++;
        if ((timeout !== 1'b0) || (bits[9:0] !== 10'h278) || (fd_off !== 39) || (stable !== 1'b1)) begin
            errors++;
            $display("FAIL midrst_next: got %h off=%0d to=%0d expected 278 off=39 to=0",
                     bits[9:0], fd_off, timeout);
        end
        checks++;
        if (reads_cnt[0] - r0 !== 2) begin
            errors++; $display("FAIL midrst_reads: got %0d expected 2", reads_cnt[0] - r0);
        end
    endtask

    task automatic test_min_cpb();
        logic [10:0] bits; int fd_off, fd_cnt, waited; bit stable, busy_ok, timeout;
        logic [9:0] exp_b [2];
        int r0 = reads_cnt[2];
        exp_b = '{10'h2AA, 10'h354};
        push(2, 8'h55); push(2, 8'hAA);
        for (int i = 0; i < 2; i++) begin
            capture(2, 2, 10, bits, fd_off, fd_cnt, stable, busy_ok, waited, timeout);
            checks++;
            if ((timeout !== 1'b0) || (bits[9:0] !== exp_b[i]) || (fd_off !== 19) ||
                (fd_cnt !== 1) || (stable !== 1'b1) || (busy_ok !== 1'b1)) begin
                errors++;
                $display("FAIL min_cpb_frame%0d: got %h off=%0d n=%0d st=%0d to=%0d expected %h off=19 n=1 st=1 to=0",
                         i, bits[9:0], fd_off, fd_cnt, stable, timeout, exp_b[i]);
            end
            if (i == 1) begin
                checks++;
                if (waited !== 0) begin
                    errors++; $display("FAIL min_cpb_gap: got wait=%0d expected 0", waited);
                end
            end
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (reads_cnt[2] - r0 !== 2) begin
            errors++; $display("FAIL min_cpb_reads: got %0d expected 2", reads_cnt[2] - r0);
        end
    endtask

    initial begin
        test_reset();
        test_parity();
        test_idle_empty();
        test_frame_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_min_cpb();
        checks++;
        if (bad_reads[0] + bad_reads[1] + bad_reads[2] !== 0) begin
            errors++;
            $display("FAIL illegal_reads: got %0d expected 0", bad_reads[0] + bad_reads[1] + bad_reads[2]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
